uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//  Frame sequencer for the UART_TX datapath. Accepts a byte request, then steps the line through
//  START, DATA (serializer shifting), optional PARITY and STOP. Drives the serializer enable, the
//  serializer/parity data-load strobe and the output-mux select, and reports busy. Supports
//  back-to-back frames with no idle bit. One frame bit per CLK cycle; CLK is the bit clock.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame; also the bit-counter terminal count (>=2)
//  STOP_BITS   1  stop bits per frame; legal values 1 or 2
// PORTS
//  CLK         in   1                      bit clock; all state changes on rising edge
//  RST         in   1                      asynchronous, active-high reset
//  Data_Valid  in   1                      frame request; sampled only when the block can accept
//  PAR_EN      in   1                      parity enable; captured at acceptance
//  load        out  1                      1-cycle accept strobe; serializer/parity register P_DATA
//  ser_en      out  1                      serializer shift enable; high for every DATA cycle
//  ser_done    out  1                      high in the last DATA cycle (count == DATA_WIDTH-1)
//  mux_sel     out  2                      line source, see encoding below
//  busy        out  1                      high from the first START cycle to the last STOP cycle
// BEHAVIOUR
//  - States: IDLE, START, DATA, PARITY, STOP. Bit counter bit_cnt [$clog2(DATA_WIDTH)-1:0] and
//    stop counter stop_cnt (1 bit). State and counters are registers; outputs decode from state.
//  - mux_sel: 2'b00 = start (0), 2'b01 = stop/idle (1), 2'b10 = serial data, 2'b11 = parity.
//  - Reset (any time, incl. mid-frame): state=IDLE, counters=0, par_en_q=0; busy=0, ser_en=0,
//    ser_done=0, load=0, mux_sel=2'b01 (line high). Takes effect immediately, no frame completion.
//  - Accept condition: acc = Data_Valid & (state==IDLE | (state==STOP & last stop bit)).
//    load = acc (combinational, same cycle). On that edge: par_en_q<=PAR_EN, state<=START.
//  - Data_Valid while busy and not in the last STOP bit is ignored (no load, no queueing).
//  - IDLE: mux_sel=01, busy=0. Stays until acc.
//  - START: one cycle, mux_sel=00, busy=1, bit_cnt<=0, -> DATA.
//  - DATA: mux_sel=10, ser_en=1, busy=1. bit_cnt increments each cycle; when bit_cnt==DATA_WIDTH-1
//    (ser_done=1) -> PARITY if par_en_q else STOP; bit_cnt<=0.
//  - PARITY: one cycle, mux_sel=11, busy=1, -> STOP, stop_cnt<=0.
//  - STOP: mux_sel=01, busy=1. Last stop bit when stop_cnt==STOP_BITS-1. On last bit: acc -> START
//    (busy stays 1, no gap), else -> IDLE. Otherwise stop_cnt increments.
//  - Frame length in cycles: 1 + DATA_WIDTH + par_en_q + STOP_BITS. Latency: Data_Valid sampled at
//    edge k -> start bit on line in cycle k+1.
//  - PAR_EN changes mid-frame do not affect the current frame. Unreachable state codes -> IDLE.
// STRUCTURE
//  - Package uart_tx_pkg: state enum/localparams (IDLE..STOP), mux_sel codes (MUX_START, MUX_STOP,
//    MUX_DATA, MUX_PAR). Shared with the serializer and the output mux.
//  - One sub-module: uart_tx_bit_cnt (clear, enable, terminal count at DATA_WIDTH-1 -> done).
//    FSM, stop counter and output decode stay in uart_tx_ctrl.
// TESTING
//  1. Reset, Data_Valid=1 for 1 cycle, PAR_EN=1: load 1 cycle; mux_sel 00,10x8,11,01; busy=1 for
//     exactly 11 cycles; ser_en=1 for 8 cycles; ser_done only in 8th data cycle.
//  2. Same with PAR_EN=0: no 11 code; busy 10 cycles; PAR_EN toggled mid-frame has no effect.
//  3. Data_Valid held high: frames back-to-back; STOP followed directly by START; busy never drops;
//     load pulses once per frame, in the STOP cycle.
//  4. Data_Valid pulses during START/DATA/PARITY: no load, frame unchanged; returns to IDLE after STOP.
//  5. RST asserted in 4th DATA cycle: same cycle busy=0, ser_en=0, mux_sel=01; next request after
//     release yields a complete, correct frame.
//  6. STOP_BITS=2, DATA_WIDTH=7, PAR_EN=1: 1+7+1+2 = 11 busy cycles; two 01 cycles.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART TX definitions: frame sequencer states and output-mux line-source codes.
// Latency: none (types and constants only).
// Backpressure: n/a.
package uart_tx_pkg;

  // Frame sequencer states; codes 5..7 are unreachable and recover to ST_IDLE
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Output-mux select: which source drives the TX line
  localparam logic [1:0] MUX_START = 2'b00;  // constant 0
  localparam logic [1:0] MUX_STOP  = 2'b01;  // constant 1 (stop and idle)
  localparam logic [1:0] MUX_DATA  = 2'b10;  // serializer output
  localparam logic [1:0] MUX_PAR   = 2'b11;  // parity bit

endpackage

// File: rtl/uart_tx_bit_cnt.sv
// Data-bit counter: counts DATA cycles, flags the terminal count DATA_WIDTH-1 and wraps to 0.
// Latency: done decodes the current count combinationally; the count updates on the next edge.
// Backpressure: none; counts whenever en is high, clr has priority.
module uart_tx_bit_cnt #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  clr,
  input  logic                                  en,
  output logic [$clog2(DATA_WIDTH)-1:0]         cnt,
  output logic                                  done
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  assign done = (cnt == LAST);

  // Clear on request, otherwise step while enabled and wrap after the last data bit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: START, DATA, optional PARITY, STOP; drives serializer and line mux.
// Latency: request sampled at edge k puts the start bit on the line in cycle k+1.
// Backpressure: requests are accepted only in IDLE or the last stop bit; others are dropped.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  output logic       load,
  output logic       ser_en,
  output logic       ser_done,
  output logic [1:0] mux_sel,
  output logic       busy
);

  localparam logic STOP_LAST = (STOP_BITS == 2);

  state_t                          state;
  logic                            stop_cnt;
  logic                            par_en_q;
  logic [$clog2(DATA_WIDTH)-1:0]   bit_cnt;
  logic                            bit_done;
  logic                            last_stop;
  logic                            acc;

  // The counter is cleared during START so every frame begins counting from zero
  uart_tx_bit_cnt #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bit_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (state == ST_START),
    .en   (state == ST_DATA),
    .cnt  (bit_cnt),
    .done (bit_done)
  );

  assign last_stop = (state == ST_STOP) && (stop_cnt == STOP_LAST);
  assign acc       = Data_Valid && ((state == ST_IDLE) || last_stop);

  // Frame sequencing; parity enable is captured at acceptance so mid-frame changes are ignored
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      stop_cnt <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc) begin
            par_en_q <= PAR_EN;
            state    <= ST_START;
          end
        end
        ST_START: begin
          state <= ST_DATA;
        end
        ST_DATA: begin
          if (bit_done) begin
            stop_cnt <= 1'b0;
            state    <= par_en_q ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          stop_cnt <= 1'b0;
          state    <= ST_STOP;
        end
        ST_STOP: begin
          if (last_stop) begin
            stop_cnt <= 1'b0;
            if (acc) begin
              par_en_q <= PAR_EN;
              state    <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: begin
          stop_cnt <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from state so an asynchronous reset idles the line in the same cycle
  always_comb begin
    load     = acc;
    ser_en   = 1'b0;
    ser_done = 1'b0;
    mux_sel  = MUX_STOP;
    busy     = 1'b0;
    case (state)
      ST_START: begin
        mux_sel = MUX_START;
        busy    = 1'b1;
      end
      ST_DATA: begin
        mux_sel  = MUX_DATA;
        ser_en   = 1'b1;
        ser_done = bit_done;
        busy     = 1'b1;
      end
      ST_PARITY: begin
        mux_sel = MUX_PAR;
        busy    = 1'b1;
      end
      ST_STOP: begin
        mux_sel = MUX_STOP;
        busy    = 1'b1;
      end
      default: begin
        mux_sel = MUX_STOP;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: per-cycle vector table on an 8-bit/1-stop instance,
// plus a hand-written sequence on a 7-bit/2-stop instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled 4 units after it.
module tb_uart_tx_ctrl;
  import uart_tx_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       dv, pe, dv2, pe2;
  logic       ld, sen, sd, bsy;
  logic [1:0] mux;
  logic       ld2, sen2, sd2, bsy2;
  logic [1:0] mux2;

  int nvec = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut (
    .CLK(CLK), .RST(RST), .Data_Valid(dv), .PAR_EN(pe),
    .load(ld), .ser_en(sen), .ser_done(sd), .mux_sel(mux), .busy(bsy)
  );

  uart_tx_ctrl #(.DATA_WIDTH(7), .STOP_BITS(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .Data_Valid(dv2), .PAR_EN(pe2),
    .load(ld2), .ser_en(sen2), .ser_done(sd2), .mux_sel(mux2), .busy(bsy2)
  );

  typedef struct {
    int         tid;
    logic       dv, pe, rst;
    logic       ld, sen, sd;
    logic [1:0] mux;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void row(input int tid, input logic d, input logic p, input logic r,
                              input logic l, input logic se, input logic sdn,
                              input logic [1:0] m, input logic b);
    vec_t v;
    v.tid = tid; v.dv = d; v.pe = p; v.rst = r;
    v.ld = l; v.sen = se; v.sd = sdn; v.mux = m; v.busy = b;
    tbl.push_back(v);
  endfunction

  // n DATA cycles of an 8-bit frame; ser_done expected only on the 8th
  function automatic void data_rows(input int tid, input int n, input logic d, input logic p);
    for (int i = 0; i < n; i++)
      row(tid, d, p, 1'b0, 1'b0, 1'b1, (i == 7), 2'b10, 1'b1);
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  initial begin
    int busy_cnt, stop_cnt, ld_cnt, sen_cnt, sd_cnt, tail;

    RST = 1'b1; dv = 1'b0; pe = 1'b0; dv2 = 1'b0; pe2 = 1'b0;

    // 1: single request with parity; PAR_EN dropped after acceptance
    row(1, 0, 0, 1, 0, 0, 0, 2'b01, 0);
    row(1, 1, 1, 0, 1, 0, 0, 2'b01, 0);
    row(1, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    data_rows(1, 8, 0, 0);
    row(1, 0, 0, 0, 0, 0, 0, 2'b11, 1);
    row(1, 0, 0, 0, 0, 0, 0, 2'b01, 1);
    row(1, 0, 0, 0, 0, 0, 0, 2'b01, 0);
    // 2: no parity; PAR_EN raised mid-frame must not add a parity bit
    row(2, 1, 0, 0, 1, 0, 0, 2'b01, 0);
    row(2, 0, 1, 0, 0, 0, 0, 2'b00, 1);
    data_rows(2, 8, 0, 1);
    row(2, 0, 1, 0, 0, 0, 0, 2'b01, 1);
    row(2, 0, 0, 0, 0, 0, 0, 2'b01, 0);
    // 3: Data_Valid held; back-to-back frames, load only in STOP, parity recaptured for frame 3
    row(3, 1, 0, 0, 1, 0, 0, 2'b01, 0);
    row(3, 1, 0, 0, 0, 0, 0, 2'b00, 1);
    data_rows(3, 8, 1, 0);
    row(3, 1, 0, 0, 1, 0, 0, 2'b01, 1);
    row(3, 1, 0, 0, 0, 0, 0, 2'b00, 1);
    data_rows(3, 8, 1, 0);
    row(3, 1, 1, 0, 1, 0, 0, 2'b01, 1);
    row(3, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    data_rows(3, 8, 0, 0);
    row(3, 0, 0, 0, 0, 0, 0, 2'b11, 1);
    row(3, 0, 0, 0, 0, 0, 0, 2'b01, 1);
    row(3, 0, 0, 0, 0, 0, 0, 2'b01, 0);
    // 4: requests during START/DATA/PARITY are ignored
    row(4, 1, 1, 0, 1, 0, 0, 2'b01, 0);
    row(4, 1, 0, 0, 0, 0, 0, 2'b00, 1);
    data_rows(4, 8, 1, 0);
    row(4, 1, 0, 0, 0, 0, 0, 2'b11, 1);
    row(4, 0, 0, 0, 0, 0, 0, 2'b01, 1);
    row(4, 0, 0, 0, 0, 0, 0, 2'b01, 0);
    // 5: reset in the 4th DATA cycle, then a clean frame with parity
    row(5, 1, 0, 0, 1, 0, 0, 2'b01, 0);
    row(5, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    data_rows(5, 3, 0, 0);
    row(5, 0, 0, 1, 0, 0, 0, 2'b01, 0);
    row(5, 0, 0, 0, 0, 0, 0, 2'b01, 0);
    row(5, 1, 1, 0, 1, 0, 0, 2'b01, 0);
    row(5, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    data_rows(5, 8, 0, 0);
    row(5, 0, 0, 0, 0, 0, 0, 2'b11, 1);
    row(5, 0, 0, 0, 0, 0, 0, 2'b01, 1);
    row(5, 0, 0, 0, 0, 0, 0, 2'b01, 0);

    foreach (tbl[i]) begin
      @(posedge CLK);
      #1;
      RST = tbl[i].rst; dv = tbl[i].dv; pe = tbl[i].pe;
      #3;
      chk($sformatf("t%0d load", tbl[i].tid), i, int'(ld), int'(tbl[i].ld));
      chk($sformatf("t%0d ser_en", tbl[i].tid), i, int'(sen), int'(tbl[i].sen));
      chk($sformatf("t%0d ser_done", tbl[i].tid), i, int'(sd), int'(tbl[i].sd));
      chk($sformatf("t%0d mux_sel", tbl[i].tid), i, int'(mux), int'(tbl[i].mux));
      chk($sformatf("t%0d busy", tbl[i].tid), i, int'(bsy), int'(tbl[i].busy));
    end

    // 6: DATA_WIDTH=7, STOP_BITS=2, parity on, Data_Valid held through the first frame
    busy_cnt = 0; stop_cnt = 0; ld_cnt = 0; sen_cnt = 0; sd_cnt = 0;
    for (int c = 0; c < 13; c++) begin
      @(posedge CLK);
      #1;
      dv2 = 1'b1;
      pe2 = (c == 0) || (c == 11);
      #3;
      if (ld2) ld_cnt++;
      if (c >= 1 && c <= 11) begin
        if (bsy2) busy_cnt++;
        if (bsy2 && mux2 == MUX_STOP) stop_cnt++;
        if (sen2) sen_cnt++;
        if (sd2) sd_cnt++;
      end
      if (c == 0)  chk("t6 load idle", c, int'(ld2), 1);
      if (c == 10) chk("t6 load first stop", c, int'(ld2), 0);
      if (c == 11) chk("t6 load last stop", c, int'(ld2), 1);
      if (c == 12) begin
        chk("t6 mux back-to-back start", c, int'(mux2), int'(MUX_START));
        chk("t6 busy back-to-back", c, int'(bsy2), 1);
      end
    end
    chk("t6 busy cycles", 0, busy_cnt, 11);
    chk("t6 stop cycles", 0, stop_cnt, 2);
    chk("t6 ser_en cycles", 0, sen_cnt, 7);
    chk("t6 ser_done cycles", 0, sd_cnt, 1);
    chk("t6 load pulses", 0, ld_cnt, 2);

    // Second frame (already in START) must run 10 more busy cycles, then go idle
    tail = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK);
      #1;
      dv2 = 1'b0; pe2 = 1'b0;
      #3;
      if (!bsy2) break;
      tail++;
    end
    chk("t6 second frame tail", 0, tail, 10);
    chk("t6 idle line", 0, int'(mux2), int'(MUX_STOP));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
